// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the adder operand sequencer: the buffered operand
// pair, the response-register state and the signed-overflow rule.
package adder_seq_pkg;

    localparam int W_DEFAULT = 32;

    typedef struct packed {
        logic signed [W_DEFAULT-1:0] a;
        logic signed [W_DEFAULT-1:0] b;
    } operand_pair_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    // Overflow needs only the sign bits: like-signed operands with a differently signed sum.
    function automatic logic f_add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_seq_fifo.sv
// Small synchronous FIFO with a head-of-queue read port and an explicit occupancy count.
// Push is ignored when full and pop is ignored when empty.
module adder_seq_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0],
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  T              i_din,
    input  logic          i_pop,
    output T              o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_count;

    // The head is read straight from the array so a popped slot exposes the next
    // entry in the same cycle; a freshly pushed entry appears only after the edge.
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Buffers signed operand pairs, presents the oldest to an external adder stage and
// registers each returned sum with its overflow flag onto a valid/ready response.
module adder_operand_sequencer
    import adder_seq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  W     = W_DEFAULT,
    localparam int PW    = $clog2(DEPTH + 2)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    input  logic [W-1:0]  i_req_a,
    input  logic [W-1:0]  i_req_b,
    output logic          o_req_ready,
    output logic [W-1:0]  o_add_a,
    output logic [W-1:0]  o_add_b,
    input  logic [W-1:0]  i_add_sum,
    output logic          o_rsp_valid,
    output logic [W-1:0]  o_rsp_sum,
    output logic          o_rsp_ovf,
    input  logic          i_rsp_ready,
    output logic [PW-1:0] o_pending
);

    localparam int CW = $clog2(DEPTH + 1);

    operand_pair_t  w_din;
    operand_pair_t  w_head;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_load;
    logic [W-1:0]   w_add_a;
    logic [W-1:0]   w_add_b;
    logic           w_ovf;
    logic           w_valid_next;
    logic [CW-1:0]  w_count_next;
    logic [PW-1:0]  w_pending_next;

    rsp_state_t     r_state;
    logic [W-1:0]   r_rsp_sum;
    logic           r_rsp_ovf;
    logic [PW-1:0]  r_pending;

    assign w_din = '{a: i_req_a, b: i_req_b};

    adder_seq_fifo #(
        .DEPTH (DEPTH),
        .T     (operand_pair_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_load),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign o_req_ready = !w_full;
    assign w_push      = i_req_valid && !w_full;
    assign w_load      = !w_empty && ((r_state == RSP_EMPTY) || i_rsp_ready);

    assign w_add_a = w_empty ? '0 : w_head.a;
    assign w_add_b = w_empty ? '0 : w_head.b;
    assign o_add_a = w_add_a;
    assign o_add_b = w_add_b;
    assign w_ovf   = f_add_ovf(w_add_a[W-1], w_add_b[W-1], i_add_sum[W-1]);

    // Pending is tracked as a register, so it is built from next-state values.
    assign w_valid_next   = w_load || ((r_state == RSP_FULL) && !i_rsp_ready);
    assign w_count_next   = w_count + CW'(w_push) - CW'(w_load);
    assign w_pending_next = PW'(w_count_next) + PW'(w_valid_next);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= RSP_EMPTY;
            r_rsp_sum <= '0;
            r_rsp_ovf <= 1'b0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
            case (r_state)
                RSP_EMPTY: begin
                    if (w_load) begin
                        r_state   <= RSP_FULL;
                        r_rsp_sum <= i_add_sum;
                        r_rsp_ovf <= w_ovf;
                    end
                end
                RSP_FULL: begin
                    if (w_load) begin
                        r_rsp_sum <= i_add_sum;
                        r_rsp_ovf <= w_ovf;
                    end else if (i_rsp_ready) begin
                        r_state <= RSP_EMPTY;
                    end
                end
                default: r_state <= RSP_EMPTY;
            endcase
        end
    end

    assign o_rsp_valid = (r_state == RSP_FULL);
    assign o_rsp_sum   = r_rsp_sum;
    assign o_rsp_ovf   = r_rsp_ovf;
    assign o_pending   = r_pending;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer: reset, single add, overflow, backpressure,
// streaming with pointer wrap and reset in the middle of a burst.
module tb_adder_operand_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int PW    = $clog2(DEPTH + 2);

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          req_ready;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_sum;
    logic          rsp_valid;
    logic [W-1:0]  rsp_sum;
    logic          rsp_ovf;
    logic          rsp_ready;
    logic [PW-1:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc;

    adder_operand_sequencer #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_add_a     (add_a),
        .o_add_b     (add_b),
        .i_add_sum   (add_sum),
        .o_rsp_valid (rsp_valid),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_ovf   (rsp_ovf),
        .i_rsp_ready (rsp_ready),
        .o_pending   (pending)
    );

    // The downstream adder stage: plain wrap-around addition.
    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance through one rising edge and stop at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset then idle
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready",   64'(req_ready), 64'(1));
        chk("rst_valid",   64'(rsp_valid), 64'(0));
        chk("rst_pending", 64'(pending),   64'(0));
        chk("rst_add_a",   64'(add_a),     64'(0));
        chk("rst_add_b",   64'(add_b),     64'(0));
        chk("rst_sum",     64'(rsp_sum),   64'(0));
        chk("rst_ovf",     64'(rsp_ovf),   64'(0));

        // Single add 5 + 7
        req_valid = 1'b1; req_a = 32'd5; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        chk("single_e1_valid",   64'(rsp_valid), 64'(0));
        chk("single_e1_add_a",   64'(add_a),     64'(5));
        chk("single_e1_add_b",   64'(add_b),     64'(7));
        chk("single_e1_pending", 64'(pending),   64'(1));
        tick();
        chk("single_e2_valid",   64'(rsp_valid), 64'(1));
        chk("single_e2_sum",     64'(rsp_sum),   64'(12));
        chk("single_e2_ovf",     64'(rsp_ovf),   64'(0));
        chk("single_e2_pending", 64'(pending),   64'(1));
        rsp_ready = 1'b1;
        tick();
        chk("single_done_valid",   64'(rsp_valid), 64'(0));
        chk("single_done_pending", 64'(pending),   64'(0));
        chk("single_done_sum_hold", 64'(rsp_sum),  64'(12));

        // Signed overflow in both directions
        req_valid = 1'b1; req_a = 32'h7FFF_FFFF; req_b = 32'h0000_0001;
        tick();
        req_a = 32'h8000_0000; req_b = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        chk("ovf_pos_valid", 64'(rsp_valid), 64'(1));
        chk("ovf_pos_sum",   64'(rsp_sum),   64'h8000_0000);
        chk("ovf_pos_ovf",   64'(rsp_ovf),   64'(1));
        tick();
        chk("ovf_neg_sum",   64'(rsp_sum),   64'h7FFF_FFFF);
        chk("ovf_neg_ovf",   64'(rsp_ovf),   64'(1));
        tick();
        chk("ovf_done_valid",   64'(rsp_valid), 64'(0));
        chk("ovf_done_pending", 64'(pending),   64'(0));

        // Backpressure: six offered, five fit (four buffered plus one held)
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 1; k <= 6; k++) begin
            req_valid = 1'b1; req_a = 32'(k); req_b = 32'd100;
            if (req_ready) n_acc++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepted", 64'(n_acc),     64'(5));
        chk("bp_ready",    64'(req_ready), 64'(0));
        chk("bp_pending",  64'(pending),   64'(5));
        chk("bp_valid",    64'(rsp_valid), 64'(1));
        chk("bp_sum",      64'(rsp_sum),   64'(101));
        tick();
        chk("bp_sum_stable",     64'(rsp_sum), 64'(101));
        chk("bp_pending_stable", 64'(pending), 64'(5));
        rsp_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            chk($sformatf("bp_drain%0d_valid", j), 64'(rsp_valid), 64'(1));
            chk($sformatf("bp_drain%0d_sum", j),   64'(rsp_sum),   64'(100 + j));
            tick();
        end
        chk("bp_drained_valid",   64'(rsp_valid), 64'(0));
        chk("bp_drained_pending", 64'(pending),   64'(0));

        // Streaming pairs (i, 2i): one result per cycle, 3i in order, pointers wrap
        for (int t = 0; t <= 17; t++) begin
            req_valid = (t < 16);
            req_a = 32'(t);
            req_b = 32'(2 * t);
            if (t < 16) chk($sformatf("stream%0d_ready", t), 64'(req_ready), 64'(1));
            tick();
            if (t == 0 || t == 17) begin
                chk($sformatf("stream%0d_idle", t), 64'(rsp_valid), 64'(0));
            end else begin
                chk($sformatf("stream%0d_valid", t), 64'(rsp_valid), 64'(1));
                chk($sformatf("stream%0d_sum", t),   64'(rsp_sum),   64'(3 * (t - 1)));
            end
        end
        req_valid = 1'b0;
        chk("stream_done_pending", 64'(pending), 64'(0));

        // Reset in the middle of a burst
        rsp_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            req_valid = 1'b1; req_a = 32'(10 * k); req_b = 32'd1;
            tick();
        end
        req_valid = 1'b0;
        chk("mid_pending", 64'(pending),   64'(4));
        chk("mid_valid",   64'(rsp_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   64'(rsp_valid), 64'(0));
        chk("mid_rst_pending", 64'(pending),   64'(0));
        chk("mid_rst_ready",   64'(req_ready), 64'(1));
        chk("mid_rst_add_a",   64'(add_a),     64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        rsp_ready = 1'b1;
        tick();
        chk("post_rst_no_stale", 64'(rsp_valid), 64'(0));
        req_valid = 1'b1; req_a = 32'd1; req_b = 32'd2;
        tick();
        req_valid = 1'b0;
        tick();
        chk("post_rst_valid", 64'(rsp_valid), 64'(1));
        chk("post_rst_sum",   64'(rsp_sum),   64'(3));
        tick();
        chk("post_rst_done",  64'(rsp_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Upstream feeder for the interface-exported adder task consumer.
- Accepts operand pairs over a valid/ready request channel and buffers them in a FIFO.
- Presents the FIFO head to the downstream combinational adder stage, which drives its sum back into this block.
- Registers each sum with a signed-overflow flag onto a valid/ready response channel.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- W, 32, operand and sum width; matches int.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request operand pair valid.
- i_req_a  input  W  operand a, signed.
- i_req_b  input  W  operand b, signed.
- o_req_ready  output  1  FIFO can accept a pair.
- o_add_a  output  W  FIFO head operand a to the adder stage.
- o_add_b  output  W  FIFO head operand b to the adder stage.
- i_add_sum  input  W  combinational sum of o_add_a + o_add_b from the adder stage.
- o_rsp_valid  output  1  response holds a result.
- o_rsp_sum  output  W  registered sum.
- o_rsp_ovf  output  1  signed overflow of that sum.
- i_rsp_ready  input  1  consumer accepts the response.
- o_pending  output  $clog2(DEPTH+2)  pairs in FIFO plus the held response.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - FIFO empty; read and write pointers 0.
  - o_rsp_valid=0, o_rsp_sum=0, o_rsp_ovf=0, o_pending=0.
  - o_req_ready=1 on the first cycle after reset release.
- Push:
  - Occurs when i_req_valid and o_req_ready are both high.
  - o_req_ready = (fifo_count < DEPTH); it depends on registered count only, not on a same-cycle pop.
- Adder drive:
  - o_add_a/o_add_b = FIFO head entry when non-empty; 0 when empty.
- Response register states: EMPTY (o_rsp_valid=0), FULL (o_rsp_valid=1).
  - load = fifo non-empty AND (EMPTY OR i_rsp_ready).
  - On load: pop the head, capture o_rsp_sum = i_add_sum and o_rsp_ovf = (a[W-1]==b[W-1]) AND (sum[W-1]!=a[W-1]); state becomes FULL.
  - FULL and i_rsp_ready and FIFO empty: state becomes EMPTY; o_rsp_sum/o_rsp_ovf hold their last values.
  - FULL and i_rsp_ready low: everything holds stable and no pop occurs (backpressure).
- Latency and throughput:
  - A pair accepted at edge N drives the adder from cycle N+1.
  - Its result gives o_rsp_valid=1 after edge N+1, i.e. a 2-edge latency into an idle block.
  - Sustained throughput is 1 pair/cycle while i_rsp_ready=1.
- Arithmetic: wrap-around modulo 2^W; overflow is reported on o_rsp_ovf, never saturated.
- Pointers: log2(DEPTH) bits, natural wrap; a separate count register holds 0..DEPTH.
- Simultaneous push and pop: count unchanged; the pushed data lands behind the popped head.
- Push into an empty FIFO: the head is not visible to the adder until the next cycle; there is no bypass.
- o_pending = fifo_count + o_rsp_valid, registered; maximum DEPTH+1.
- Reset mid-operation discards all buffered pairs and any held response immediately.
- Ordering: responses appear in strict request order.

Decomposition:
- Shared package adder_seq_pkg:
  - typedef operand_pair_t (struct of a, b, each logic signed [W-1:0]);
  - localparam W_DEFAULT=32;
  - function f_add_ovf(a, b, sum).
- One sub-module, adder_seq_fifo:
  - parameterised by DEPTH and element type;
  - provides push, pop, head, count, full and empty;
  - same i_clk / i_rst_n.
- The top block contains only the response register, ready logic and the pending counter.

Test Plan:
- Reset then idle: hold i_rst_n low for 3 cycles, release -> o_req_ready=1, o_rsp_valid=0, o_pending=0, o_add_a=o_add_b=0.
- Single add: push a=5, b=7 with the adder model summing -> o_rsp_valid rises 2 edges after the accept, o_rsp_sum=12, o_rsp_ovf=0; after i_rsp_ready, o_pending returns to 0.
- Overflow: push (0x7FFFFFFF, 1), then (0x80000000, 0xFFFFFFFF) -> sums 0x80000000 and 0x7FFFFFFF, both with o_rsp_ovf=1.
- Backpressure/full: i_rsp_ready=0 and push 6 pairs -> 5 accepted (4 in FIFO + 1 held), o_req_ready=0, o_pending=5, response stable; release ready -> 5 results in order.
- Streaming: i_rsp_ready=1 and continuous pairs (i, 2i) for i=0..15 -> after the initial 2-edge latency, one result per cycle, sums 3i in order, pointers wrap without loss.
- Reset mid-burst: assert i_rst_n low with 3 pairs buffered and a response held -> o_rsp_valid=0 and o_pending=0 asynchronously, and no stale result appears after release.
